// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
// Both FSMs count in prescaler ticks; one bit spans TICKS_PER_BIT ticks.
package uart_pkg;

   localparam int TICKS_PER_BIT = 4;
   localparam int DATA_BITS     = 8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_CHECK_START,
      RX_READ_BITS,
      RX_CHECK_STOP,
      RX_FINISH_STOP,
      RX_ERROR
   } rx_state_t;

   typedef enum logic {
      TX_IDLE,
      TX_SENDING
   } tx_state_t;

endpackage

// File: rtl/uart_tick_gen.sv
// Quarter-bit prescaler: down-counter that fires a tick at zero and reloads.
// restart realigns the tick phase to the start of a frame.
module uart_tick_gen #(
   parameter int CLOCK_DIVIDE = 2604
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
   localparam logic [W-1:0] RELOAD = W'(CLOCK_DIVIDE - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (restart || cnt == '0) begin
         cnt <= RELOAD;
      end else begin
         cnt <= cnt - W'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with 4x oversampling and independent RX/TX prescalers.
// RX samples at bit centres, realigned on every start edge.
module uart_transceiver
   import uart_pkg::*;
#(
   parameter int CLOCK_DIVIDE = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       tx,
   input  logic       transmit,
   input  logic [7:0] tx_byte,
   output logic       received,
   output logic [7:0] rx_byte,
   output logic       is_receiving,
   output logic       is_transmitting,
   output logic       recv_error
);

   localparam logic [3:0] HALF_T  = 4'(TICKS_PER_BIT / 2 - 1);
   localparam logic [3:0] BIT_T   = 4'(TICKS_PER_BIT - 1);
   localparam logic [3:0] ERR_T   = 4'(2 * TICKS_PER_BIT - 1);
   localparam logic [2:0] RX_LAST = 3'(DATA_BITS - 1);
   localparam logic [3:0] TX_LAST = 4'(DATA_BITS + 1);

   rx_state_t  rx_state;
   tx_state_t  tx_state;
   logic       rx_s1;
   logic       rx_s2;
   logic       rx_tick;
   logic       tx_tick;
   logic       rx_restart;
   logic       tx_restart;
   logic       rx_due;
   logic [3:0] rx_cnt;
   logic [2:0] rx_bit;
   logic [7:0] rx_shift;
   logic [3:0] tx_cnt;
   logic [3:0] tx_idx;
   logic [8:0] tx_shift;

   assign rx_restart      = (rx_state == RX_IDLE) && !rx_s2;
   assign tx_restart      = (tx_state == TX_IDLE) && transmit;
   assign rx_due          = rx_tick && (rx_cnt == '0);
   assign is_receiving    = (rx_state != RX_IDLE);
   assign is_transmitting = (tx_state != TX_IDLE);

   uart_tick_gen #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_rx_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (rx_restart),
      .tick    (rx_tick)
   );

   uart_tick_gen #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_tx_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (tx_restart),
      .tick    (tx_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_byte    <= '0;
         received   <= 1'b0;
         recv_error <= 1'b0;
      end else begin
         received   <= 1'b0;
         recv_error <= 1'b0;
         if (rx_tick && rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 4'd1;
         end
         unique case (rx_state)
            RX_IDLE: begin
               if (!rx_s2) begin
                  rx_state <= RX_CHECK_START;
                  rx_cnt   <= HALF_T;
               end
            end
            RX_CHECK_START: begin
               if (rx_due) begin
                  if (!rx_s2) begin
                     rx_state <= RX_READ_BITS;
                     rx_cnt   <= BIT_T;
                     rx_bit   <= '0;
                  end else begin
                     rx_state <= RX_IDLE;
                  end
               end
            end
            RX_READ_BITS: begin
               if (rx_due) begin
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_cnt   <= BIT_T;
                  if (rx_bit == RX_LAST) begin
                     rx_state <= RX_CHECK_STOP;
                  end else begin
                     rx_bit <= rx_bit + 3'd1;
                  end
               end
            end
            RX_CHECK_STOP: begin
               if (rx_due) begin
                  if (rx_s2) begin
                     rx_state <= RX_FINISH_STOP;
                     rx_cnt   <= HALF_T;
                  end else begin
                     rx_state   <= RX_ERROR;
                     recv_error <= 1'b1;
                     rx_cnt     <= ERR_T;
                  end
               end
            end
            RX_FINISH_STOP: begin
               if (rx_due) begin
                  rx_byte  <= rx_shift;
                  received <= 1'b1;
                  rx_state <= RX_IDLE;
               end
            end
            RX_ERROR: begin
               if (rx_due) begin
                  rx_state <= RX_IDLE;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Shift register carries the stop bit above the data so the
   // frame falls out of bit 0 in wire order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state <= TX_IDLE;
         tx       <= 1'b1;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
      end else begin
         unique case (tx_state)
            TX_IDLE: begin
               if (transmit) begin
                  tx_state <= TX_SENDING;
                  tx       <= 1'b0;
                  tx_shift <= {1'b1, tx_byte};
                  tx_idx   <= '0;
                  tx_cnt   <= BIT_T;
               end
            end
            TX_SENDING: begin
               if (tx_tick) begin
                  if (tx_cnt != '0) begin
                     tx_cnt <= tx_cnt - 4'd1;
                  end else if (tx_idx == TX_LAST) begin
                     tx_state <= TX_IDLE;
                     tx       <= 1'b1;
                  end else begin
                     tx       <= tx_shift[0];
                     tx_shift <= {1'b1, tx_shift[8:1]};
                     tx_idx   <= tx_idx + 4'd1;
                     tx_cnt   <= BIT_T;
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transceiver.sv
// Two transceivers on slightly mismatched clocks wired back-to-back,
// with per-direction scoreboards fed at transmit time.
`timescale 1ns/1ps
module tb_uart_transceiver;

   localparam int DIV = 4;
   localparam int BIT_CLK = 4 * DIV;

   logic       clk_a = 1'b0;
   logic       clk_b = 1'b0;
   logic       rst_a;
   logic       rst_b;
   logic       a_tx, b_tx, b_rx;
   logic       a_transmit, b_transmit;
   logic [7:0] a_tx_byte, b_tx_byte;
   logic       a_received, b_received;
   logic [7:0] a_rx_byte, b_rx_byte;
   logic       a_is_rx, b_is_rx, a_is_tx, b_is_tx;
   logic       a_err, b_err;
   logic       drv_en;
   logic       drv_val;

   int         n_assert = 0;
   int         n_fail = 0;
   int         a_rx_cnt = 0;
   int         b_rx_cnt = 0;
   int         a_err_cnt = 0;
   int         b_err_cnt = 0;
   realtime    t_acc;
   realtime    t_b_rx;
   logic [7:0] qa[$];
   logic [7:0] qb[$];

   always #5 clk_a = ~clk_a;
   always #4.99 clk_b = ~clk_b;

   assign b_rx = drv_en ? drv_val : a_tx;

   uart_transceiver #(.CLOCK_DIVIDE(DIV)) u_a (
      .clk             (clk_a),
      .rst             (rst_a),
      .rx              (b_tx),
      .tx              (a_tx),
      .transmit        (a_transmit),
      .tx_byte         (a_tx_byte),
      .received        (a_received),
      .rx_byte         (a_rx_byte),
      .is_receiving    (a_is_rx),
      .is_transmitting (a_is_tx),
      .recv_error      (a_err)
   );

   uart_transceiver #(.CLOCK_DIVIDE(DIV)) u_b (
      .clk             (clk_b),
      .rst             (rst_b),
      .rx              (b_rx),
      .tx              (b_tx),
      .transmit        (b_transmit),
      .tx_byte         (b_tx_byte),
      .received        (b_received),
      .rx_byte         (b_rx_byte),
      .is_receiving    (b_is_rx),
      .is_transmitting (b_is_tx),
      .recv_error      (b_err)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_b) begin
      if (b_received === 1'b1) begin
         b_rx_cnt++;
         t_b_rx = $realtime;
         n_assert++;
         assert (qb.size() > 0) else begin
            n_fail++;
            $error("FAIL b_unexpected_rx: observed %0h expected none", b_rx_byte);
         end
         if (qb.size() > 0) begin
            automatic logic [7:0] e = qb.pop_front();
            n_assert++;
            assert (b_rx_byte === e) else begin
               n_fail++;
               $error("FAIL b_rx_byte: observed %0h expected %0h", b_rx_byte, e);
            end
         end
         n_assert++;
         assert (b_err === 1'b0) else begin
            n_fail++;
            $error("FAIL b_rx_and_err: observed %0b expected 0", b_err);
         end
      end
      if (b_err === 1'b1) b_err_cnt++;
   end

   always @(negedge clk_a) begin
      if (a_received === 1'b1) begin
         a_rx_cnt++;
         n_assert++;
         assert (qa.size() > 0) else begin
            n_fail++;
            $error("FAIL a_unexpected_rx: observed %0h expected none", a_rx_byte);
         end
         if (qa.size() > 0) begin
            automatic logic [7:0] e = qa.pop_front();
            n_assert++;
            assert (a_rx_byte === e) else begin
               n_fail++;
               $error("FAIL a_rx_byte: observed %0h expected %0h", a_rx_byte, e);
            end
         end
      end
      if (a_err === 1'b1) a_err_cnt++;
   end

   task automatic send_a(input logic [7:0] b, input bit expect_rx);
      @(negedge clk_a);
      a_transmit = 1'b1;
      a_tx_byte  = b;
      if (expect_rx) qb.push_back(b);
      @(posedge clk_a);
      t_acc = $realtime;
      @(negedge clk_a);
      a_transmit = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      @(negedge clk_b);
      b_transmit = 1'b1;
      b_tx_byte  = b;
      qa.push_back(b);
      @(negedge clk_b);
      b_transmit = 1'b0;
   endtask

   task automatic wait_b(input int start);
      for (int i = 0; i < 400 && b_rx_cnt == start; i++) @(posedge clk_a);
   endtask

   task automatic wait_a(input int start);
      for (int i = 0; i < 400 && a_rx_cnt == start; i++) @(posedge clk_a);
   endtask

   initial begin
      int         c0;
      int         e0;
      realtime    lat;
      logic [7:0] r;

      rst_a = 1'b0;
      rst_b = 1'b0;
      a_transmit = 1'b0;
      b_transmit = 1'b0;
      a_tx_byte = '0;
      b_tx_byte = '0;
      drv_en = 1'b0;
      drv_val = 1'b1;

      #100;
      @(negedge clk_a);
      check("rst_a_tx", a_tx, 1);
      check("rst_a_received", a_received, 0);
      check("rst_a_err", a_err, 0);
      check("rst_a_rx_byte", a_rx_byte, 0);
      check("rst_a_is_rx", a_is_rx, 0);
      check("rst_a_is_tx", a_is_tx, 0);
      check("rst_b_tx", b_tx, 1);
      check("rst_b_rx_byte", b_rx_byte, 0);
      check("rst_b_is_rx", b_is_rx, 0);
      check("rst_b_is_tx", b_is_tx, 0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (20) @(negedge clk_a);

      c0 = b_rx_cnt;
      send_a(8'hFA, 1'b1);
      check("accept_tx_low", a_tx, 0);
      check("accept_is_tx", a_is_tx, 1);
      wait_b(c0);
      check("fa_rx_count", b_rx_cnt, c0 + 1);
      lat = t_b_rx - t_acc;
      n_assert++;
      assert (lat >= 1580.0 && lat <= 1700.0) else begin
         n_fail++;
         $error("FAIL latency: observed %0t expected 1580..1700 ns", lat);
      end
      check("fa_is_tx_done", a_is_tx, 0);
      check("fa_b_err", b_err_cnt, 0);
      repeat (20) @(negedge clk_a);

      for (int i = 0; i < 3; i++) begin
         r = 8'($urandom_range(0, 255));
         c0 = b_rx_cnt;
         send_a(r, 1'b1);
         wait_b(c0);
         check("a2b_rx_count", b_rx_cnt, c0 + 1);
         repeat (30) @(negedge clk_a);
      end
      for (int i = 0; i < 3; i++) begin
         r = 8'($urandom_range(0, 255));
         c0 = a_rx_cnt;
         send_b(r);
         wait_a(c0);
         check("b2a_rx_count", a_rx_cnt, c0 + 1);
         repeat (30) @(negedge clk_a);
      end
      check("dup_a_err", a_err_cnt, 0);

      c0 = b_rx_cnt;
      send_a(8'hA3, 1'b1);
      repeat (50) @(negedge clk_a);
      a_transmit = 1'b1;
      a_tx_byte = 8'h55;
      @(negedge clk_a);
      a_transmit = 1'b0;
      check("ignore_still_tx", a_is_tx, 1);
      wait_b(c0);
      repeat (400) @(negedge clk_a);
      check("ignore_one_frame", b_rx_cnt, c0 + 1);
      check("ignore_tx_idle", a_is_tx, 0);
      check("ignore_tx_line", a_tx, 1);

      c0 = b_rx_cnt;
      e0 = b_err_cnt;
      drv_en = 1'b1;
      drv_val = 1'b0;
      repeat (11 * BIT_CLK) @(negedge clk_b);
      drv_val = 1'b1;
      repeat (8 * BIT_CLK) @(negedge clk_b);
      check("brk_err_pulse", b_err_cnt, e0 + 1);
      check("brk_no_rx", b_rx_cnt, c0);
      check("brk_rx_byte", b_rx_byte, 8'hA3);
      check("brk_is_rx", b_is_rx, 0);

      drv_val = 1'b0;
      repeat (DIV) @(negedge clk_b);
      drv_val = 1'b1;
      repeat (3 * DIV) @(negedge clk_b);
      check("glitch_is_rx", b_is_rx, 0);
      check("glitch_no_err", b_err_cnt, e0 + 1);
      check("glitch_no_rx", b_rx_cnt, c0);

      send_a(8'h3C, 1'b0);
      repeat (80) @(negedge clk_a);
      check("midrst_sending", a_is_tx, 1);
      rst_a = 1'b0;
      @(posedge clk_a);
      #1;
      check("midrst_tx", a_tx, 1);
      check("midrst_is_tx", a_is_tx, 0);
      check("midrst_rx_byte", a_rx_byte, 0);
      @(negedge clk_a);
      rst_a = 1'b1;
      repeat (200) @(negedge clk_a);
      check("midrst_stays_idle", a_tx, 1);

      check("qb_empty", qb.size(), 0);
      check("qa_empty", qa.size(), 0);
      check("final_a_err", a_err_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
